// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter pattern encoding and the A-H pattern table.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  // Symbols are LSB-aligned: the first symbol received sits at bit len-1.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] sym;
  } pattern_t;

  localparam pattern_t PAT_A = '{len: 3'd2, sym: 4'b0001};
  localparam pattern_t PAT_B = '{len: 3'd4, sym: 4'b1000};
  localparam pattern_t PAT_C = '{len: 3'd4, sym: 4'b1010};
  localparam pattern_t PAT_D = '{len: 3'd3, sym: 4'b0100};
  localparam pattern_t PAT_E = '{len: 3'd1, sym: 4'b0000};
  localparam pattern_t PAT_F = '{len: 3'd4, sym: 4'b0010};
  localparam pattern_t PAT_G = '{len: 3'd3, sym: 4'b0110};
  localparam pattern_t PAT_H = '{len: 3'd4, sym: 4'b0000};

  function automatic pattern_t letter_pat(input logic [2:0] letter);
    case (letter)
      3'd0:    return PAT_A;
      3'd1:    return PAT_B;
      3'd2:    return PAT_C;
      3'd3:    return PAT_D;
      3'd4:    return PAT_E;
      3'd5:    return PAT_F;
      3'd6:    return PAT_G;
      default: return PAT_H;
    endcase
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Unit stream in, decoded letter and status pulses out.
interface morse_decoder_if;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       LetterError;

  modport master (output DotDashIn, NewBitIn, input LetterOut, LetterValid, LetterError);
  modport slave  (input DotDashIn, NewBitIn, output LetterOut, LetterValid, LetterError);
endinterface

// File: rtl/morse_lookup.sv
// Combinational pattern -> letter match against the shared A-H table.
module morse_lookup
  import morse_pkg::*;
(
  input  pattern_t   pat,
  output logic       match,
  output logic [2:0] letter
);

  always_comb begin
    match  = 1'b0;
    letter = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pat == letter_pat(3'(i))) begin
        match  = 1'b1;
        letter = 3'(i);
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space run lengths on strobed units and decodes letters A-H.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 3,
  parameter int MAX_SYMBOLS = 4
) (
  input  logic           ClockIn,
  input  logic           Reset,
  morse_decoder_if.slave bus
);

  localparam logic [2:0] MARK_SAT = 3'd4;

  state_t     state;
  logic [2:0] mark_cnt;
  logic [2:0] space_cnt;
  logic [2:0] len;
  logic [3:0] sym;
  logic       err;
  logic [2:0] letter_q;
  logic       valid_q;
  logic       error_q;

  pattern_t   cur_pat;
  logic       match;
  logic [2:0] match_letter;

  assign cur_pat = '{len: len, sym: sym};

  morse_lookup u_lookup (
    .pat    (cur_pat),
    .match  (match),
    .letter (match_letter)
  );

  logic is_dot, is_dash, full, gap_done;
  assign is_dot   = (mark_cnt == 3'd1);
  assign is_dash  = (mark_cnt == 3'(DASH_UNITS));
  assign full     = (len == 3'(MAX_SYMBOLS));
  assign gap_done = ((space_cnt + 3'd1) == 3'(GAP_UNITS));

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state     <= IDLE;
      mark_cnt  <= '0;
      space_cnt <= '0;
      len       <= '0;
      sym       <= '0;
      err       <= 1'b0;
      letter_q  <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (bus.NewBitIn) begin
        case (state)
          IDLE: begin
            if (bus.DotDashIn) begin
              mark_cnt <= 3'd1;
              sym      <= '0;
              len      <= '0;
              err      <= 1'b0;
              state    <= MARK;
            end
          end
          MARK: begin
            if (bus.DotDashIn) begin
              if (mark_cnt != MARK_SAT) mark_cnt <= mark_cnt + 3'd1;
            end else begin
              // A bad mark length still appends a symbol; err already condemns the letter.
              if (!(is_dot || is_dash)) err <= 1'b1;
              if (full) begin
                err <= 1'b1;
              end else begin
                sym <= {sym[2:0], ~is_dot};
                len <= len + 3'd1;
              end
              space_cnt <= 3'd1;
              state     <= SPACE;
            end
          end
          SPACE: begin
            if (bus.DotDashIn) begin
              if (space_cnt != 3'd1) err <= 1'b1;
              mark_cnt <= 3'd1;
              state    <= MARK;
            end else if (gap_done) begin
              if (!err && match) begin
                valid_q  <= 1'b1;
                letter_q <= match_letter;
              end else begin
                error_q <= 1'b1;
              end
              state <= IDLE;
            end else begin
              space_cnt <= space_cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.LetterOut   = letter_q;
  assign bus.LetterValid = valid_q;
  assign bus.LetterError = error_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: expected letters/errors queued at drive time, popped on pulses.
module tb_morse_decoder;

  logic ClockIn = 1'b0;
  logic Reset;

  always #5 ClockIn = ~ClockIn;

  morse_decoder_if bus ();

  morse_decoder #(
    .DASH_UNITS  (3),
    .GAP_UNITS   (3),
    .MAX_SYMBOLS (4)
  ) dut (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .bus     (bus.slave)
  );

  typedef struct {
    bit         is_err;
    logic [2:0] letter;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [2:0] last_letter = 3'd0;
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_ok(input logic [2:0] l);
    last_letter = l;
    q.push_back('{is_err: 1'b0, letter: l});
  endtask

  task automatic push_err();
    q.push_back('{is_err: 1'b1, letter: last_letter});
  endtask

  // Bits are sent MSB first; non-strobe cycles carry random DotDashIn noise.
  task automatic send(input logic [31:0] bits, input int n, input int spacing, input bit pulse);
    for (int i = 0; i < n; i++) begin
      @(negedge ClockIn);
      bus.NewBitIn  = 1'b1;
      bus.DotDashIn = bits[n-1-i];
      if (i == n - 1) begin
        @(posedge ClockIn);
        #1;
        chk("latency", int'(bus.LetterValid | bus.LetterError), int'(pulse));
      end else begin
        for (int k = 1; k < spacing; k++) begin
          @(negedge ClockIn);
          bus.NewBitIn  = 1'b0;
          bus.DotDashIn = 1'($urandom_range(1, 0));
        end
      end
    end
    @(negedge ClockIn);
    bus.NewBitIn  = 1'b0;
    bus.DotDashIn = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge ClockIn);
    chk(tag, q.size(), 0);
  endtask

  always @(negedge ClockIn) begin
    if (!Reset && (bus.LetterValid || bus.LetterError)) begin
      chk("exclusive", int'(bus.LetterValid & bus.LetterError), 0);
      if (q.size() == 0) begin
        chk("pulse_expected", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("kind", int'(bus.LetterError), int'(e.is_err));
        chk("letter", int'(bus.LetterOut), int'(e.letter));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset         = 1'b1;
    bus.NewBitIn  = 1'b0;
    bus.DotDashIn = 1'b0;
    repeat (3) @(posedge ClockIn);
    #1;
    chk("rst_out",   int'(bus.LetterOut), 0);
    chk("rst_valid", int'(bus.LetterValid), 0);
    chk("rst_error", int'(bus.LetterError), 0);
    @(negedge ClockIn);
    Reset = 1'b0;

    push_ok(3'd0); send(32'b10111000, 8, 1, 1'b1);              // A
    drain("drain_a");

    push_ok(3'd7); send(32'b1010101000, 10, 1, 1'b1);           // H
    push_ok(3'd6); send(32'b111011101000, 12, 1, 1'b1);         // G
    drain("drain_hg");

    push_ok(3'd4); send(32'b1000, 4, 4, 1'b1);                  // E, sparse
    drain("drain_e");

    push_ok(3'd3); send(32'b1110101000, 10, 2, 1'b1);           // D
    push_ok(3'd1); send(32'b111010101000, 12, 1, 1'b1);         // B
    push_ok(3'd5); send(32'b101011101000, 12, 3, 1'b1);         // F
    drain("drain_dbf");

    push_err(); send(32'b11000, 5, 1, 1'b1);                    // 2-unit mark
    push_err(); send(32'b1001000, 7, 1, 1'b1);                  // 2-unit intra gap
    push_err(); send(32'b101010101000, 12, 1, 1'b1);            // five dots
    push_err(); send(32'b111011101110111000, 18, 1, 1'b1);      // dash x4
    drain("drain_err");

    // Reset mid-letter, with a strobe in the reset cycle that must be dropped.
    send(32'b101, 3, 1, 1'b0);
    @(negedge ClockIn);
    Reset         = 1'b1;
    bus.NewBitIn  = 1'b1;
    bus.DotDashIn = 1'b1;
    @(posedge ClockIn);
    #1;
    chk("midrst_valid", int'(bus.LetterValid | bus.LetterError), 0);
    chk("midrst_out",   int'(bus.LetterOut), 0);
    last_letter = 3'd0;
    @(negedge ClockIn);
    Reset        = 1'b0;
    bus.NewBitIn = 1'b0;
    push_ok(3'd2); send(32'b11101011101000, 14, 1, 1'b1);      // C
    drain("drain_c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver for letters A–H. It sits directly downstream of the Morse encoder/transmitter stage. It consumes the DotDashOut / NewBitOut unit stream, where each NewBit strobe marks one half-second Morse unit. It measures mark and space run lengths, assembles up to four dot/dash symbols, and emits the decoded 3-bit letter code (A=0 … H=7) with a one-cycle valid pulse, or an error pulse for a malformed or unknown pattern.

## Interface
Parameters:
- DASH_UNITS, 3: high units forming a dash (a dot is 1 unit).
- GAP_UNITS, 3: consecutive low units that terminate a letter.
- MAX_SYMBOLS, 4: maximum symbols per letter.

Ports:
- ClockIn  input  1  system clock. One clock; all logic on posedge ClockIn.
- Reset  input  1  synchronous, active-high reset.
- DotDashIn  input  1  unit value (1 = tone), valid only when NewBitIn=1.
- NewBitIn  input  1  one-cycle strobe: sample DotDashIn this cycle.
- LetterOut  output  3  decoded letter code; holds its last value between pulses.
- LetterValid  output  1  one-cycle pulse: LetterOut updated with a good letter.
- LetterError  output  1  one-cycle pulse: letter discarded.

## Operation
- Symbol coding: dot=0, dash=1. The first symbol is the MSB of the used bits. Pattern = {len[2:0], sym[3:0]}.
- Patterns:
  - A: len 2, sym 01
  - B: len 4, sym 1000
  - C: len 4, sym 1010
  - D: len 3, sym 100
  - E: len 1, sym 0
  - F: len 4, sym 0010
  - G: len 3, sym 110
  - H: len 4, sym 0000
- State advances only on cycles with NewBitIn=1. DotDashIn is ignored on all other cycles.
- FSM states:
  - IDLE: a low unit is ignored. A high unit sets mark_cnt=1, clears sym/len/err, and moves to MARK.
  - MARK:
    - A high unit increments mark_cnt, saturating at 4.
    - A low unit classifies the mark: 1 → dot; DASH_UNITS → dash; anything else → set err.
    - If len == MAX_SYMBOLS already, set err (overflow) and do not append. Otherwise shift the symbol into sym and increment len.
    - Then set space_cnt=1 and move to SPACE.
  - SPACE:
    - A high unit: if space_cnt==1 (intra-letter gap), set mark_cnt=1 and go to MARK. If space_cnt==2, set err, set mark_cnt=1 and go to MARK.
    - A low unit increments space_cnt. When space_cnt reaches GAP_UNITS the letter ends:
      - If err=0 and the pattern matches: pulse LetterValid and load LetterOut.
      - Otherwise pulse LetterError; LetterOut is unchanged.
      - Go to IDLE.
- A stream that stays high never terminates. The FSM remains in MARK with mark_cnt saturated.
- Reset (any state, mid-letter included): state=IDLE; counters, sym, len and err cleared; no pulse generated.

## Timing
- Reset values: LetterOut=0, LetterValid=0, LetterError=0.
- All outputs are registered.
- Latency: LetterValid or LetterError is high in the cycle immediately after the edge that samples the GAP_UNITS-th low strobe. It stays high exactly one cycle.
- LetterValid and LetterError are never high together.
- Back-to-back strobes on consecutive clocks are supported. Minimum strobe spacing is 1 cycle.
- Reset and NewBitIn in the same cycle: Reset wins and the strobe is dropped.

## Structure
- morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE);
  - the pattern typedef (len + sym);
  - the eight letter pattern constants, shared with the encoder.
- Sub-module morse_lookup: combinational pattern → {match, letter[2:0]}. Instantiated once.
- Estimated size: ~150–200 lines total.

## Test plan
- A after reset: strobes every cycle with bits 1,0,1,1,1,0,0,0 → LetterValid pulse one cycle after the 8th strobe, LetterOut=0, LetterError=0.
- H, then G back-to-back:
  - H: 1,0,1,0,1,0,1,0,0,0 → LetterOut=7.
  - Then G: 1,1,1,0,1,1,1,0,1,0,0,0 → LetterOut=6.
  - Exactly two LetterValid pulses.
- Sparse strobes (NewBitIn every 4th clock), DotDashIn toggling randomly between strobes, strobed bits 1,0,0,0 → LetterOut=4 (E). Non-strobe values have no effect.
- Malformed input, each → LetterError pulse, no LetterValid, LetterOut unchanged:
  - mark of 2 units (1,1,0,0,0);
  - 2-unit intra gap (1,0,0,1,0,0,0);
  - five dots;
  - unknown pattern dash-dash-dash-dash.
- Reset after strobes 1,0,1 (mid-letter) → no pulse. A following C stream 1,1,1,0,1,0,1,1,1,0,1,0,0,0 → LetterOut=2.
